// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// rtl/serial_adder_fa_bit.sv - gate-level 1-bit full adder cell used by the serial adder
module fa_bit (
  input  logic Ai,
  input  logic Bi,
  input  logic Cin,
  output logic Fi,
  output logic Cout
);

  logic w_axb;
  logic w_ab;
  logic w_pc;

  xor g_x0 (w_axb, Ai, Bi);
  xor g_x1 (Fi, w_axb, Cin);
  and g_a0 (w_ab, Ai, Bi);
  and g_a1 (w_pc, w_axb, Cin);
  or  g_o0 (Cout, w_ab, w_pc);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one bit per clock, LSB first
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             OF
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_f;
  logic [WIDTH-1:0] w_fsh;
  logic             r_cy;
  logic             r_cmsb;
  logic [CW-1:0]    r_cnt;
  logic             w_fi;
  logic             w_co;

  fa_bit u_fa (
    .Ai   (r_a[0]),
    .Bi   (r_b[0]),
    .Cin  (r_cy),
    .Fi   (w_fi),
    .Cout (w_co)
  );

  // new sum bit enters at the top; after WIDTH shifts bit 0 sits at the bottom
  assign w_fsh = {w_fi, r_f};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_last  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy    = 1'b1;
        w_shift = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last = 1'b1;
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_f    <= '0;
      r_cy   <= 1'b0;
      r_cmsb <= 1'b0;
      r_cnt  <= '0;
      F      <= '0;
      Cout   <= 1'b0;
      OF     <= 1'b0;
    end else if (w_load) begin
      r_a   <= A;
      r_b   <= B;
      r_cy  <= Cin0;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_f   <= w_fsh[WIDTH-1:1];
      r_cy  <= w_co;
      r_cnt <= r_cnt + CNT_ONE;
      if (r_cnt == CNT_MSB) r_cmsb <= w_co;
      if (w_last) begin
        F    <= w_fsh;
        Cout <= w_co;
        OF   <= r_cmsb ^ w_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=2 instances)
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       Cin0 = 1'b0;
  logic       busy, done, Cout, OF;
  logic [7:0] F;

  logic       s2_start = 1'b0;
  logic [1:0] s2_A = '0;
  logic [1:0] s2_B = '0;
  logic       s2_Cin0 = 1'b0;
  logic       s2_busy, s2_done, s2_Cout, s2_OF;
  logic [1:0] s2_F;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin0(Cin0),
    .busy(busy), .done(done), .F(F), .Cout(Cout), .OF(OF)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .A(s2_A), .B(s2_B), .Cin0(s2_Cin0),
    .busy(s2_busy), .done(s2_done), .F(s2_F), .Cout(s2_Cout), .OF(s2_OF)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Waits for done from the sample just after the accepting edge and checks result vs plain arithmetic.
  task automatic wait_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic c, input int glitch_at);
    int n = 0;
    int nb = 0;
    logic [8:0] sum;
    logic ov;
    sum = {1'b0, a} + {1'b0, b} + {8'd0, c};
    ov  = (a[7] == b[7]) && (sum[7] != a[7]);
    while (!done && n < 20) begin
      if (busy) nb++;
      if (glitch_at >= 0 && n == glitch_at) begin
        start = 1'b1; A = 8'($urandom); B = 8'($urandom); Cin0 = 1'($urandom);
      end else if (glitch_at >= 0 && n == glitch_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 8);
    check({tag, "_busycyc"}, nb, 8);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_F"}, F, sum[7:0]);
    check({tag, "_Cout"}, Cout, sum[8]);
    check({tag, "_OF"}, OF, ov);
  endtask

  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input int glitch_at);
    @(negedge clk);
    A = a; B = b; Cin0 = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 8'($urandom); B = 8'($urandom); Cin0 = 1'($urandom);
    wait_result(tag, a, b, c, glitch_at);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic run_add2(input logic [1:0] a, input logic [1:0] b, input logic c);
    int n = 0;
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {2'd0, c};
    @(negedge clk);
    s2_A = a; s2_B = b; s2_Cin0 = c; s2_start = 1'b1;
    @(negedge clk);
    s2_start = 1'b0;
    while (!s2_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("w2_lat", n, 2);
    check("w2_F", s2_F, sum[1:0]);
    check("w2_Cout", s2_Cout, sum[2]);
    check("w2_OF", s2_OF, (a[1] == b[1]) && (sum[1] != a[1]));
  endtask

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_F", F, 0);
    check("rst_CoutOF", {Cout, OF}, 0);
    rst = 1'b0;

    run_add("d0f01", 8'h0F, 8'h01, 1'b0, -1);
    run_add("dff01", 8'hFF, 8'h01, 1'b0, -1);
    run_add("dff00c", 8'hFF, 8'h00, 1'b1, -1);
    run_add("d7f01", 8'h7F, 8'h01, 1'b0, -1);
    run_add("d8080", 8'h80, 8'h80, 1'b0, -1);
    run_add("ignore", 8'h11, 8'h22, 1'b0, 3);

    // start held high through DONE: second add accepted on the DONE edge
    @(negedge clk);
    A = 8'h11; B = 8'h22; Cin0 = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 8'h40; B = 8'h05; Cin0 = 1'b1;
    wait_result("b2b_1", 8'h11, 8'h22, 1'b0, -1);
    @(negedge clk);
    start = 1'b0;
    wait_result("b2b_2", 8'h40, 8'h05, 1'b1, -1);
    @(negedge clk);

    // reset between edges mid-SHIFT
    @(negedge clk);
    A = 8'h33; B = 8'h44; Cin0 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_F", F, 0);
    check("arst_CoutOF", {Cout, OF}, 0);
    check("arst_busy_done", {busy, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("arst_no_done", nd, 0);
    run_add("post_rst", 8'h05, 8'h03, 1'b0, -1);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run_add("rand", ra, rb, rc, (i % 4 == 0) ? int'($urandom_range(0, 5)) : -1);
    end

    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      vv = 5'(v);
      run_add2(vv[4:3], vv[2:1], vv[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
